axi_wr_master: RTL and testbench

AXI4 write master between the DDR burst controller and the MIG AXI slave port, in the `ui_clk` domain. It accepts one burst request at a time (address plus beat count), launches a single INCR burst on AW, and streams beats out of the controller's first-word-fall-through write FIFO on W. It waits for the B response, then pulses `wr_burst_finish` so the controller advances its address pointer. It is the responder to the controller's `wr_burst_req`/`wr_ready`/`wr_fifo_re`/`wr_burst_finish` handshake.

---
 rtl/axi_wr_pkg.sv | 21 ++
 rtl/axi_wr_master_if.sv | 49 ++++
 rtl/axi_wr_master.sv | 150 +++++++++++++++
 tb/tb_axi_wr_master.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_wr_pkg.sv
// Shared AXI4 write-master types and constants for the DDR write path.
package axi_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [3:0]  CACHE_DEF  = 4'b0011;
  localparam int unsigned MAX_BEATS  = 256;

  // AXI size encoding (log2 of bytes per beat) for a given data width
  function automatic logic [2:0] axi_size(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_wr_master_if.sv
// AXI4 write-channel bundle (AW, W, B) with master and slave views.
interface axi_wr_master_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4
);

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_wr_master.sv
// Single-burst AXI4 write master fed by a FWFT write FIFO (IDLE -> AW -> W -> B).
// Optional BRESP error tracking is enabled by defining AXI_WR_BRESP_CHK_EN.
module axi_wr_master
  import axi_wr_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic               ui_clk,
  input  logic               ui_rst,
  input  logic               i_wr_burst_req,
  input  logic [ADDR_W-1:0]  i_wr_burst_addr,
  input  logic [9:0]         i_wr_burst_len,
  output logic               o_wr_ready,
  output logic               o_wr_fifo_re,
  input  logic [DATA_W-1:0]  i_wr_fifo_data,
  input  logic               i_wr_fifo_empty,
  output logic               o_wr_burst_finish,
  output logic               o_wr_len_err,
  axi_wr_master_if.master    m_axi
`ifdef AXI_WR_BRESP_CHK_EN
  ,
  output logic               o_wr_resp_err,
  output logic [15:0]        o_wr_resp_err_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_AW    = 2'(ST_AW);
  localparam logic [1:0] S_W     = 2'(ST_W);
  localparam logic [1:0] S_B     = 2'(ST_B);
  localparam logic [2:0] AW_SIZE = axi_size(DATA_W);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_awaddr;
  logic [7:0]        r_awlen;
  logic [7:0]        r_beat_cnt;
  logic              r_wr_ready;
  logic              r_awvalid;
  logic              r_bready;
  logic              r_finish;
  logic              r_len_err;

  logic w_len_ok;
  logic w_req_ok;
  logic w_req_bad;
  logic w_aw_hs;
  logic w_wvalid;
  logic w_wlast;
  logic w_w_hs;
  logic w_b_hs;
  logic w_unused;

  assign w_len_ok  = (i_wr_burst_len != 10'd0) && (i_wr_burst_len <= 10'(MAX_BEATS));
  assign w_req_ok  = (r_state == S_IDLE) && i_wr_burst_req && w_len_ok;
  assign w_req_bad = (r_state == S_IDLE) && i_wr_burst_req && !w_len_ok;
  assign w_aw_hs   = r_awvalid & m_axi.awready;
  assign w_wvalid  = (r_state == S_W) & ~i_wr_fifo_empty;
  assign w_wlast   = (r_state == S_W) && (r_beat_cnt == r_awlen);
  assign w_w_hs    = w_wvalid & m_axi.wready;
  assign w_b_hs    = r_bready & m_axi.bvalid;
  assign w_unused  = ^{m_axi.bid, m_axi.bresp};

  // State register
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_ok)           w_state_nxt = S_AW;
      S_AW:    if (w_aw_hs)            w_state_nxt = S_W;
      S_W:     if (w_w_hs && w_wlast)  w_state_nxt = S_B;
      S_B:     if (w_b_hs)             w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs, request latch and beat counter
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      r_wr_ready <= 1'b1;
      r_awvalid  <= 1'b0;
      r_bready   <= 1'b0;
      r_finish   <= 1'b0;
      r_len_err  <= 1'b0;
      r_awaddr   <= '0;
      r_awlen    <= 8'd0;
      r_beat_cnt <= 8'd0;
    end else begin
      r_wr_ready <= (w_state_nxt == S_IDLE);
      r_awvalid  <= (w_state_nxt == S_AW);
      r_bready   <= (w_state_nxt == S_B);
      r_finish   <= w_b_hs;
      if (w_req_bad) r_len_err <= 1'b1;
      if (w_req_ok) begin
        r_awaddr <= i_wr_burst_addr;
        r_awlen  <= 8'(i_wr_burst_len - 10'd1);
      end
      if (w_aw_hs)     r_beat_cnt <= 8'd0;
      else if (w_w_hs) r_beat_cnt <= r_beat_cnt + 8'd1;
    end
  end

`ifdef AXI_WR_BRESP_CHK_EN
  logic        r_resp_err;
  logic [15:0] r_resp_err_cnt;

  // Sticky error flag and saturating count of non-OKAY write responses
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      r_resp_err     <= 1'b0;
      r_resp_err_cnt <= 16'd0;
    end else if (w_b_hs && (m_axi.bresp != RESP_OKAY)) begin
      r_resp_err <= 1'b1;
      if (r_resp_err_cnt != 16'hFFFF) r_resp_err_cnt <= r_resp_err_cnt + 16'd1;
    end
  end

  assign o_wr_resp_err     = r_resp_err;
  assign o_wr_resp_err_cnt = r_resp_err_cnt;
`endif

  assign o_wr_ready        = r_wr_ready;
  assign o_wr_fifo_re      = w_w_hs;
  assign o_wr_burst_finish = r_finish;
  assign o_wr_len_err      = r_len_err;

  assign m_axi.awid    = '0;
  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awlen   = r_awlen;
  assign m_axi.awsize  = AW_SIZE;
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = CACHE_DEF;
  assign m_axi.awprot  = 3'd0;
  assign m_axi.awqos   = 4'd0;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = i_wr_fifo_data;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = w_wlast;
  assign m_axi.wvalid  = w_wvalid;
  assign m_axi.bready  = r_bready;

endmodule

// File: tb/tb_axi_wr_master.sv
// Scoreboard bench for axi_wr_master: FIFO/AXI-slave model, directed bursts, queue-based monitor.
module tb_axi_wr_master;

  localparam int unsigned P_DW = 64;
  localparam int unsigned P_AW = 32;
  localparam int unsigned P_IW = 4;

  logic              ui_clk = 1'b0;
  logic              ui_rst;
  logic              req;
  logic [P_AW-1:0]   baddr;
  logic [9:0]        blen;
  logic [P_DW-1:0]   fdata;
  logic              fempty;
  logic              wr_ready;
  logic              fifo_re;
  logic              finish;
  logic              len_err;
`ifdef AXI_WR_BRESP_CHK_EN
  logic              resp_err;
  logic [15:0]       resp_cnt;
`endif

  axi_wr_master_if #(.DATA_W(P_DW), .ADDR_W(P_AW), .ID_W(P_IW)) m_axi ();

  axi_wr_master #(.DATA_W(P_DW), .ADDR_W(P_AW), .ID_W(P_IW)) dut (
    .ui_clk            (ui_clk),
    .ui_rst            (ui_rst),
    .i_wr_burst_req    (req),
    .i_wr_burst_addr   (baddr),
    .i_wr_burst_len    (blen),
    .o_wr_ready        (wr_ready),
    .o_wr_fifo_re      (fifo_re),
    .i_wr_fifo_data    (fdata),
    .i_wr_fifo_empty   (fempty),
    .o_wr_burst_finish (finish),
    .o_wr_len_err      (len_err),
    .m_axi             (m_axi)
`ifdef AXI_WR_BRESP_CHK_EN
    ,
    .o_wr_resp_err     (resp_err),
    .o_wr_resp_err_cnt (resp_cnt)
`endif
  );

  always #5 ui_clk = ~ui_clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] fifo_q[$];
  logic [31:0] exp_aa[$];
  logic [7:0]  exp_al[$];
  int          exp_ah[$];
  logic [63:0] exp_wd[$];
  bit          exp_wl[$];

  int       aw_delay  = 0;
  int       b_delay   = 0;
  bit       w_toggle  = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;

  int cyc = 0, aw_total = 0, w_total = 0, re_total = 0, fin_total = 0;
  int aw_hold = 0;
  bit fin_due = 1'b0;
  int fin_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // AXI slave + FWFT FIFO model; acts on handshakes sampled at the preceding negedge
  initial begin : slave
    bit aw_f, w_f, wl_f, b_f, awv;
    int awv_cnt, b_cnt;
    bit b_pend;
    awv_cnt = 0; b_cnt = 0; b_pend = 1'b0;
    m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.bvalid = 1'b0;
    m_axi.bresp = 2'b00; m_axi.bid = '0;
    fempty = 1'b1; fdata = '0;
    forever begin
      @(negedge ui_clk);
      awv  = m_axi.awvalid;
      aw_f = awv && m_axi.awready;
      w_f  = m_axi.wvalid && m_axi.wready;
      wl_f = w_f && m_axi.wlast;
      b_f  = m_axi.bvalid && m_axi.bready;
      @(posedge ui_clk);
      #2;
      if (ui_rst) begin
        awv_cnt = 0; b_pend = 1'b0; b_cnt = 0;
        fifo_q.delete();
        m_axi.wready = 1'b0;
      end else begin
        if (aw_f)     awv_cnt = 0;
        else if (awv) awv_cnt++;
        if (w_f && fifo_q.size() > 0) fifo_q.delete(0);
        if (b_f) b_pend = 1'b0;
        if (wl_f) begin b_pend = 1'b1; b_cnt = 0; end
        else if (b_pend && !m_axi.bvalid) b_cnt++;
        m_axi.wready = w_toggle ? ~m_axi.wready : 1'b1;
      end
      m_axi.awready = m_axi.awvalid && (awv_cnt >= aw_delay);
      m_axi.bvalid  = b_pend && (b_cnt >= b_delay);
      m_axi.bresp   = bresp_cfg;
      fempty        = (fifo_q.size() == 0);
      fdata         = fempty ? '0 : fifo_q[0];
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a handshake
  always @(negedge ui_clk) begin : monitor
    cyc++;
    if (ui_rst) begin
      aw_hold = 0;
      fin_due = 1'b0;
    end else begin
      if (fin_due) begin
        chk("finish_pulse", 64'(finish), 64'd1);
        chk("ready_after_b", 64'(wr_ready), 64'd1);
        fin_due = 1'b0;
      end else if (finish) begin
        checks++; errors++;
        $display("FAIL finish_unexpected act=1 exp=0 t=%0t", $time);
      end
      if (finish) begin fin_total++; fin_cyc.push_back(cyc); end
      if (fifo_re) re_total++;
      if (m_axi.awvalid) aw_hold++;
      if (m_axi.awvalid && m_axi.awready) begin
        aw_total++;
        if (exp_aa.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_unexpected act=%0h exp=none t=%0t", m_axi.awaddr, $time);
        end else begin
          chk("awaddr", 64'(m_axi.awaddr), 64'(exp_aa[0]));
          chk("awlen", 64'(m_axi.awlen), 64'(exp_al[0]));
          chk("aw_hold_cycles", 64'(aw_hold), 64'(exp_ah[0]));
          chk("aw_const", 64'({m_axi.awsize, m_axi.awburst, m_axi.awcache, m_axi.awid}),
              64'({3'd3, 2'b01, 4'b0011, 4'd0}));
          exp_aa.delete(0); exp_al.delete(0); exp_ah.delete(0);
        end
        aw_hold = 0;
      end
      if (m_axi.wvalid && m_axi.wready) begin
        w_total++;
        chk("fifo_re", 64'(fifo_re), 64'd1);
        if (exp_wd.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected act=%0h exp=none t=%0t", m_axi.wdata, $time);
        end else begin
          chk("wdata", m_axi.wdata, exp_wd[0]);
          chk("wlast", 64'(m_axi.wlast), 64'(exp_wl[0]));
          chk("wstrb", 64'(m_axi.wstrb), 64'hFF);
          exp_wd.delete(0); exp_wl.delete(0);
        end
      end
      if (m_axi.bvalid && m_axi.bready) fin_due = 1'b1;
    end
  end

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!wr_ready && n < 3000) begin tick(); n++; end
    chk("wait_ready", 64'(wr_ready), 64'd1);
  endtask

  task automatic wait_fin(input int target);
    int n = 0;
    while (fin_total < target && n < 3000) begin tick(); n++; end
    chk("wait_finish", 64'(fin_total >= target), 64'd1);
  endtask

  task automatic wait_w(input int target);
    int n = 0;
    while (w_total < target && n < 3000) begin tick(); n++; end
    chk("wait_beats", 64'(w_total >= target), 64'd1);
  endtask

  task automatic push_exp(input logic [31:0] a, input int n, input int d0, input int nload);
    exp_aa.push_back(a);
    exp_al.push_back(8'(n - 1));
    exp_ah.push_back(aw_delay + 1);
    for (int i = 0; i < n; i++) begin
      exp_wd.push_back(64'(d0 + i));
      exp_wl.push_back(i == n - 1);
    end
    for (int i = 0; i < nload; i++) fifo_q.push_back(64'(d0 + i));
  endtask

  // One request pulse plus the controller's one-cycle registered lag
  task automatic issue(input logic [31:0] a, input int n, input int d0, input int nload);
    push_exp(a, n, d0, nload);
    wait_ready();
    req = 1'b1; baddr = a; blen = 10'(n);
    tick();
    tick();
    req = 1'b0;
  endtask

  task automatic issue_bad(input int n);
    wait_ready();
    req = 1'b1; baddr = 32'h0000_0C00; blen = 10'(n);
    tick();
    tick();
    req = 1'b0;
    tick();
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog act=timeout exp=finish t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base_fin, base_aw, base_w, base_re, hi;
    ui_rst = 1'b1; req = 1'b0; baddr = '0; blen = 10'd0;
    repeat (3) tick();
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_awvalid", 64'(m_axi.awvalid), 64'd0);
    chk("rst_wvalid", 64'(m_axi.wvalid), 64'd0);
    chk("rst_wlast", 64'(m_axi.wlast), 64'd0);
    chk("rst_bready", 64'(m_axi.bready), 64'd0);
    chk("rst_fifo_re", 64'(fifo_re), 64'd0);
    chk("rst_finish", 64'(finish), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_awaddr", 64'(m_axi.awaddr), 64'd0);
    chk("rst_awlen", 64'(m_axi.awlen), 64'd0);
`ifdef AXI_WR_BRESP_CHK_EN
    chk("rst_resp_err", 64'({resp_err, resp_cnt}), 64'd0);
`endif
    ui_rst = 1'b0;
    tick();

    // Basic 128-beat burst from a preloaded FIFO
    base_fin = fin_total;
    issue(32'h0000_0400, 128, 0, 128);
    wait_fin(base_fin + 1);
    tick();
    chk("t1_finish_count", 64'(fin_total - base_fin), 64'd1);

    // AW stalled 5 cycles, WREADY toggling
    aw_delay = 5; w_toggle = 1'b1;
    base_fin = fin_total; base_re = re_total;
    issue(32'h0000_0800, 128, 1000, 128);
    wait_fin(base_fin + 1);
    chk("t2_fifo_re_count", 64'(re_total - base_re), 64'd128);
    aw_delay = 0; w_toggle = 1'b0;

    // FIFO runs dry after 64 words and is refilled 10 cycles later
    base_fin = fin_total; base_w = w_total;
    issue(32'h0000_0C00, 128, 2000, 64);
    wait_w(base_w + 64);
    hi = 0;
    repeat (10) begin
      @(negedge ui_clk);
      if (m_axi.wvalid) hi++;
    end
    chk("t3_gap_wvalid_high", 64'(hi), 64'd0);
    tick();
    for (int i = 64; i < 128; i++) fifo_q.push_back(64'(2000 + i));
    wait_fin(base_fin + 1);
    chk("t3_beats", 64'(w_total - base_w), 64'd128);

    // Illegal lengths are dropped and flagged; a len-1 burst still works
    base_aw = aw_total;
    issue_bad(0);
    chk("t4_len_err_len0", 64'(len_err), 64'd1);
    issue_bad(300);
    chk("t4_len_err_len300", 64'(len_err), 64'd1);
    chk("t4_no_aw", 64'(aw_total - base_aw), 64'd0);
    chk("t4_awvalid_idle", 64'(m_axi.awvalid), 64'd0);
    base_fin = fin_total;
    issue(32'h0000_1000, 1, 'hABCD, 1);
    wait_fin(base_fin + 1);
    chk("t4_len_err_sticky", 64'(len_err), 64'd1);

    // Request held high across three bursts with delayed BVALID
    b_delay = 3;
    base_fin = fin_total; base_aw = aw_total;
    fin_cyc.delete();
    for (int k = 0; k < 3; k++) push_exp(32'h0000_2000, 4, 3000 + 4 * k, 0);
    for (int i = 0; i < 12; i++) fifo_q.push_back(64'(3000 + i));
    wait_ready();
    req = 1'b1; baddr = 32'h0000_2000; blen = 10'd4;
    for (int n = 0; n < 3000 && (aw_total - base_aw) < 3; n++) tick();
    req = 1'b0;
    wait_fin(base_fin + 3);
    repeat (12) tick();
    chk("t5_aw_count", 64'(aw_total - base_aw), 64'd3);
    chk("t5_finish_count", 64'(fin_cyc.size()), 64'd3);
    for (int k = 1; k < fin_cyc.size(); k++)
      chk("t5_finish_gap_ge_7", 64'((fin_cyc[k] - fin_cyc[k-1]) >= 7), 64'd1);
    b_delay = 0;

    // Reset asserted at beat 50 of a 128-beat burst
    base_w = w_total;
    issue(32'h0000_3000, 128, 4000, 128);
    wait_w(base_w + 50);
    #2;
    ui_rst = 1'b1;
    #1;
    chk("mid_rst_awvalid", 64'(m_axi.awvalid), 64'd0);
    chk("mid_rst_wvalid", 64'(m_axi.wvalid), 64'd0);
    chk("mid_rst_wlast", 64'(m_axi.wlast), 64'd0);
    chk("mid_rst_bready", 64'(m_axi.bready), 64'd0);
    chk("mid_rst_fifo_re", 64'(fifo_re), 64'd0);
    chk("mid_rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("mid_rst_len_err", 64'(len_err), 64'd0);
    exp_aa.delete(); exp_al.delete(); exp_ah.delete();
    exp_wd.delete(); exp_wl.delete();
    repeat (3) tick();
    ui_rst = 1'b0;
    tick();

    // Clean burst after reset, answered with SLVERR
    bresp_cfg = 2'b10;
    base_fin = fin_total;
    issue(32'h0000_4000, 8, 5000, 8);
    wait_fin(base_fin + 1);
    tick();
    chk("post_rst_queue_empty", 64'(exp_wd.size()), 64'd0);
`ifdef AXI_WR_BRESP_CHK_EN
    chk("resp_err", 64'(resp_err), 64'd1);
    chk("resp_err_cnt", 64'(resp_cnt), 64'd1);
`endif
    bresp_cfg = 2'b00;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
